// File: rtl/tl_acquire_responder.sv
// Manager-side TileLink-C acquire responder: one tracker that refills a line from backing memory,
// returns Grant/GrantData on D and waits for the matching GrantAck on E.
module tl_acquire_responder #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned SRC_W   = 2,
   parameter int unsigned SINK_W  = 2,
   parameter int unsigned BEATS   = 8,
   parameter int unsigned SINK_ID = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_valid_i,
   output logic              a_ready_o,
   input  logic [2:0]        a_opcode_i,
   input  logic [2:0]        a_param_i,
   input  logic [3:0]        a_size_i,
   input  logic [SRC_W-1:0]  a_source_i,
   input  logic [ADDR_W-1:0] a_address_i,
   output logic              d_valid_o,
   input  logic              d_ready_i,
   output logic [2:0]        d_opcode_o,
   output logic [1:0]        d_param_o,
   output logic [3:0]        d_size_o,
   output logic [SRC_W-1:0]  d_source_o,
   output logic [SINK_W-1:0] d_sink_o,
   output logic              d_denied_o,
   output logic [DATA_W-1:0] d_data_o,
   input  logic              e_valid_i,
   output logic              e_ready_o,
   input  logic [SINK_W-1:0] e_sink_i,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   input  logic              mem_resp_valid_i,
   input  logic [DATA_W-1:0] mem_resp_data_i
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned ByteW = $clog2(BYTES);
   localparam int unsigned CntW  = $clog2(BEATS) + 1;
   localparam int unsigned IdxW  = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'(BEATS * BYTES - 1);
   localparam logic [CntW-1:0]   BeatsC   = CntW'(BEATS);
   localparam logic [CntW-1:0]   LastBeat = CntW'(BEATS - 1);
   localparam logic [SINK_W-1:0] SinkId   = SINK_W'(SINK_ID);

   localparam logic [2:0] OpAcquireBlock = 3'd6;
   localparam logic [2:0] OpAcquirePerm  = 3'd7;
   localparam logic [2:0] OpGrant        = 3'd4;
   localparam logic [2:0] OpGrantData    = 3'd5;

   typedef enum logic [1:0] {StIdle, StFill, StSend, StAck} state_e;

   state_e              state_q;
   logic                a_ready_q, d_valid_q, e_ready_q, mreq_valid_q;
   logic [ADDR_W-1:0]   mreq_addr_q, base_q;
   logic [2:0]          d_opcode_q;
   logic [1:0]          d_param_q;
   logic [3:0]          d_size_q;
   logic [SRC_W-1:0]    d_source_q;
   logic                d_denied_q;
   logic [DATA_W-1:0]   d_data_q;
   logic [CntW-1:0]     req_cnt_q, req_cnt_d;
   logic [CntW-1:0]     rsp_cnt_q, rsp_cnt_d;
   logic [CntW-1:0]     beat_q, beat_d;
   logic [DATA_W-1:0]   buf_q [BEATS];

   logic a_fire, req_fire, resp_fire, d_fire, e_fire, legal;

   assign a_fire    = a_valid_i & a_ready_q;
   assign req_fire  = mreq_valid_q & mem_req_ready_i;
   assign resp_fire = (state_q == StFill) & mem_resp_valid_i & (rsp_cnt_q < BeatsC);
   assign d_fire    = d_valid_q & d_ready_i;
   assign e_fire    = e_valid_i & e_ready_q;
   assign legal     = ((a_opcode_i == OpAcquireBlock) || (a_opcode_i == OpAcquirePerm)) &&
                      (a_param_i <= 3'd2);

   always_comb begin
      req_cnt_d = req_cnt_q;
      rsp_cnt_d = rsp_cnt_q;
      beat_d    = beat_q;
      if (a_fire) begin
         req_cnt_d = '0;
         rsp_cnt_d = '0;
         beat_d    = '0;
      end else begin
         if (req_fire) req_cnt_d = req_cnt_q + CntW'(1);
         if (resp_fire) rsp_cnt_d = rsp_cnt_q + CntW'(1);
         if (d_fire && (state_q == StSend) && (d_opcode_q == OpGrantData) &&
             (beat_q != LastBeat)) begin
            beat_d = beat_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         a_ready_q    <= 1'b1;
         d_valid_q    <= 1'b0;
         e_ready_q    <= 1'b0;
         mreq_valid_q <= 1'b0;
         mreq_addr_q  <= '0;
         base_q       <= '0;
         d_opcode_q   <= '0;
         d_param_q    <= '0;
         d_size_q     <= '0;
         d_source_q   <= '0;
         d_denied_q   <= 1'b0;
         d_data_q     <= '0;
         req_cnt_q    <= '0;
         rsp_cnt_q    <= '0;
         beat_q       <= '0;
         for (int i = 0; i < BEATS; i++) buf_q[i] <= '0;
      end else begin
         req_cnt_q <= req_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
         beat_q    <= beat_d;
         if (resp_fire) buf_q[rsp_cnt_q[IdxW-1:0]] <= mem_resp_data_i;

         unique case (state_q)
            StIdle: begin
               if (a_fire) begin
                  a_ready_q  <= 1'b0;
                  d_size_q   <= a_size_i;
                  d_source_q <= a_source_i;
                  d_param_q  <= (a_param_i == 3'd0) ? 2'd1 : 2'd0;
                  d_denied_q <= ~legal;
                  base_q     <= a_address_i & LineMask;
                  if ((a_opcode_i == OpAcquireBlock) && legal) begin
                     state_q      <= StFill;
                     mreq_valid_q <= 1'b1;
                     mreq_addr_q  <= a_address_i & LineMask;
                  end else begin
                     state_q    <= StSend;
                     d_valid_q  <= 1'b1;
                     d_opcode_q <= OpGrant;
                     d_data_q   <= '0;
                  end
               end
            end
            StFill: begin
               if (req_fire) begin
                  mreq_addr_q <= base_q + (ADDR_W'(req_cnt_d) << ByteW);
                  if (req_cnt_d == BeatsC) mreq_valid_q <= 1'b0;
               end
               if (resp_fire && (rsp_cnt_q == LastBeat)) begin
                  state_q    <= StSend;
                  d_valid_q  <= 1'b1;
                  d_opcode_q <= OpGrantData;
                  // Single-beat lines would otherwise read beat 0 before it is written.
                  d_data_q   <= (rsp_cnt_q == '0) ? mem_resp_data_i : buf_q[0];
               end
            end
            StSend: begin
               if (d_fire) begin
                  if ((d_opcode_q == OpGrantData) && (beat_q != LastBeat)) begin
                     d_data_q <= buf_q[beat_d[IdxW-1:0]];
                  end else begin
                     state_q   <= StAck;
                     d_valid_q <= 1'b0;
                     d_data_q  <= '0;
                     e_ready_q <= 1'b1;
                  end
               end
            end
            StAck: begin
               if (e_fire && (e_sink_i == SinkId)) begin
                  state_q   <= StIdle;
                  e_ready_q <= 1'b0;
                  a_ready_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign a_ready_o       = a_ready_q;
   assign d_valid_o       = d_valid_q;
   assign d_opcode_o      = d_opcode_q;
   assign d_param_o       = d_param_q;
   assign d_size_o        = d_size_q;
   assign d_source_o      = d_source_q;
   assign d_sink_o        = SinkId;
   assign d_denied_o      = d_denied_q;
   assign d_data_o        = d_data_q;
   assign e_ready_o       = e_ready_q;
   assign mem_req_valid_o = mreq_valid_q;
   assign mem_req_addr_o  = mreq_addr_q;

endmodule
